mux41_rr_arb: RTL and testbench

Round-robin arbiter and sequencer for the shared 4:1 data multiplexer. Four requesters compete for the single output line `y`. The block grants one requester at a time, drives the mux select `sel` and the one-hot decoder enables `gnt`, and forces a grant rotation after a bounded hold time. It sits directly in front of the 4:1 mux datapath and replaces a free-running or testbench-driven select.

---
 rtl/mux41_rr_arb.sv | 157 +++++++++++++++
 tb/tb_mux41_rr_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux41_rr_arb.sv
// Purpose : round-robin arbiter/sequencer that owns the select of a shared 4:1 data mux.
// Latency : req seen at edge N -> gnt/sel after edge N; y/valid are combinational from gnt/sel and live d.
// Backpress: none; holding req keeps the grant, which is forced to rotate after HOLD_MAX cycles of contention.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   req[3:0] - per-requester request
//   d[3:0]   - per-requester data bit (mux data inputs)
//   gnt[3:0] - one-hot grant / decoder enables, zero when idle
//   sel[1:0] - binary index of the current owner (mux select)
//   y        - d[sel] while a grant is active, else 0
//   valid    - any grant active
//   lock     - only with MUX41_ARB_LOCK_EN: suppresses the forced rotation
//              while the owner keeps requesting
//
// Optional feature macro: MUX41_ARB_LOCK_EN (adds the lock input).

module mux41_rr_arb #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
`ifdef MUX41_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y,
    output logic       valid
);

    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    sel_nxt;
    logic [1:0]    last, last_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;

    // Without the lock feature the rotation is never suppressed.
    logic lock_eff;
`ifdef MUX41_ARB_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    // First requesting index scanning base+1, base+2, base+3, base (mod 4).
    // The 2-bit add wraps naturally, so k=4 lands back on base itself.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Owner's request and everybody else's; in GRANT gnt is the one-hot of sel.
    logic       own_req;
    logic [3:0] others;
    logic [1:0] win;
    logic [HW-1:0] hold_inc;

    assign own_req  = req[sel];
    assign others   = req & ~gnt;
    assign hold_inc = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HW'(1);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        win       = 2'b00;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    win       = rr_pick(req, last);
                    gnt_nxt   = 4'(4'b0001 << win);
                    sel_nxt   = win;
                    last_nxt  = win;
                    hold_nxt  = HW'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    if (|others) begin
                        // Hand over in the same edge: no idle bubble.
                        win      = rr_pick(others, sel);
                        gnt_nxt  = 4'(4'b0001 << win);
                        sel_nxt  = win;
                        last_nxt = win;
                        hold_nxt = HW'(1);
                    end else begin
                        // sel and last keep the departing owner.
                        gnt_nxt   = 4'b0000;
                        state_nxt = IDLE;
                    end
                end else if (others == 4'b0000) begin
                    hold_nxt = hold_inc;
                end else if (hold_cnt == HOLD_SAT && !lock_eff) begin
                    // Hold time used up under contention: forced rotation.
                    win      = rr_pick(others, sel);
                    gnt_nxt  = 4'(4'b0001 << win);
                    sel_nxt  = win;
                    last_nxt = win;
                    hold_nxt = HW'(1);
                end else begin
                    hold_nxt = hold_inc;
                end
            end
            default: begin
                gnt_nxt   = 4'b0000;
                state_nxt = IDLE;
            end
        endcase
    end

    // last resets to 3 so requester 0 is first in the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'b00;
            last     <= 2'b11;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Datapath outputs are unregistered so the mux sees the grant directly.
    assign valid = |gnt;
    assign y     = valid & d[sel];

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Bench for mux41_rr_arb: directed scenarios followed by random traffic, all
// checked by a queue-based scoreboard fed from a behavioural arbitration model.

module tb_mux41_rr_arb;

    localparam int H = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
`ifdef MUX41_ARB_LOCK_EN
    logic       lock;
`endif
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       valid;

    int total = 0;
    int bad   = 0;

    mux41_rr_arb #(.HOLD_MAX(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
`ifdef MUX41_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int own;   // -1 when idle
        int sel;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner tracked as an integer index; the winner is the first requester
    // counting upward (mod 4) from a base index.
    function automatic int winner(input logic [3:0] m, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (m[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    int m_own  = -1;
    int m_last = 3;
    int m_sel  = 0;
    int m_held = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_own  = -1;
                m_last = 3;
                m_sel  = 0;
                m_held = 0;
                exp_q.delete();
            end else begin
                logic       lk;
                logic [3:0] oth;
`ifdef MUX41_ARB_LOCK_EN
                lk = lock;
`else
                lk = 1'b0;
`endif
                if (m_own < 0) begin
                    if (req != 4'b0) begin
                        m_own  = winner(req, m_last);
                        m_held = 1;
                    end
                end else if (!req[m_own]) begin
                    if (req != 4'b0) begin
                        m_own  = winner(req, m_own);
                        m_held = 1;
                    end else begin
                        m_own = -1;
                    end
                end else begin
                    oth = req;
                    oth[m_own] = 1'b0;
                    if (oth != 4'b0 && m_held >= H && !lk) begin
                        m_own  = winner(oth, m_own);
                        m_held = 1;
                    end else begin
                        m_held = (m_held < H) ? m_held + 1 : H;
                    end
                end
                if (m_own >= 0) begin
                    m_last = m_own;
                    m_sel  = m_own;
                end
                exp_q.push_back('{own: m_own, sel: m_sel});
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check("rst_gnt", int'(gnt), 0);
                check("rst_sel", int'(sel), 0);
                check("rst_valid", int'(valid), 0);
                check("rst_y", int'(y), 0);
            end else if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("gnt", int'(gnt), (e.own < 0) ? 0 : (1 << e.own));
                check("sel", int'(sel), e.sel);
                check("valid", int'(valid), (e.own < 0) ? 0 : 1);
                check("y", int'(y), (e.own < 0) ? 0 : int'(d[e.own]));
                check("onehot0", int'($onehot0(gnt)), 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Applies r/dv at the next falling edge and keeps them for n rising edges.
    task automatic drive(input logic [3:0] r, input logic [3:0] dv, input int n);
        @(negedge clk);
        req = r;
        d   = dv;
        repeat (n - 1) @(negedge clk);
    endtask

    // Reset pulse placed between edges; checks the grant drops at once.
    task automatic mid_reset(input logic [3:0] r_after);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", int'(gnt), 0);
        check("async_valid", int'(valid), 0);
        check("async_y", int'(y), 0);
        #1;
        rst_n = 1'b1;
        req   = r_after;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        d     = 4'b1111;
`ifdef MUX41_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_hold_gnt", int'(gnt), 0);
        rst_n = 1'b1;
        drive(4'b1111, 4'b1111, 2);

        // single requester, long hold, then release to idle
        drive(4'b0000, 4'b0000, 2);
        drive(4'b0100, 4'b0100, 10);
        drive(4'b0000, 4'b0100, 2);

        // full contention, rotation every H cycles
        drive(4'b1111, 4'b1010, 20);

        // early release by owner 1 with requester 3 waiting
        drive(4'b0000, 4'b1010, 2);
        drive(4'b0010, 4'b1010, 1);
        drive(4'b1010, 4'b1010, 1);
        drive(4'b1000, 4'b1111, 2);

        // reset pulse while requester 3 owns the line
        mid_reset(4'b1111);
        drive(4'b1111, 4'b0101, 6);

`ifdef MUX41_ARB_LOCK_EN
        drive(4'b0000, 4'b0000, 2);
        drive(4'b0001, 4'b0001, 1);
        lock = 1'b1;
        drive(4'b0011, 4'b0011, 12);
        lock = 1'b0;
        drive(4'b0011, 4'b0011, 4);
`endif

        // random traffic; requests persist for a few cycles on average
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            d = 4'($urandom);
`ifdef MUX41_ARB_LOCK_EN
            if ($urandom_range(0, 9) == 0) lock = ~lock;
`endif
            if ($urandom_range(0, 399) == 0) mid_reset(4'($urandom));
        end

        drive(4'b0000, 4'b0000, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
